// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the MEM-stage load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Encoding 3 is folded onto WORD.
    function automatic mem_size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return BYTE;
            2'd1:    return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic [3:0] byte_mask(input mem_size_e size, input logic [1:0] lane);
        case (size)
            BYTE:    return BE_BYTE << lane;
            HALF:    return BE_HALF << lane;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] sd);
        case (size)
            BYTE:    return {4{sd[7:0]}};
            HALF:    return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Picks the addressed byte/half out of a raw read word and sign- or zero-extends it.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] drdata,
    input  logic [1:0]  addr,
    input  mem_size_e   size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = drdata[{addr, 3'b000} +: 8];
    assign half_sel = drdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        result = drdata;
        case (size)
            BYTE:    result = {{24{is_signed & byte_sel[7]}}, byte_sel};
            HALF:    result = {{16{is_signed & half_sel[15]}}, half_sel};
            default: result = drdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: one outstanding req/ack data access, stalls the pipe while busy.
//   state | meaning
//   IDLE  | pass-through to MEM/WB, launch aligned memory ops
//   BUS   | dreq held, waiting for dack or timeout
//   DONE  | present latched result to MEM/WB, release stall
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        reg_write,
    input  logic        mem_2_reg,
    input  logic [4:0]  rd,
    input  logic [31:0] alu_data,
    input  logic [31:0] store_data,
    output logic        reg_write_out,
    output logic        mem_2_reg_out,
    output logic [4:0]  rd_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] mem_data_out,
    output logic        stall,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dreq,
    output logic        dwe,
    output logic [3:0]  dbe,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    input  logic        dack,
    input  logic [31:0] drdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       lat_rd;
    logic             lat_rw;
    logic             lat_m2r;
    logic [31:0]      lat_addr;
    mem_size_e        lat_size;
    logic             lat_signed;
    logic             lat_read;
    logic             err;
    logic [31:0]      ld_data;

    mem_size_e        size_in;
    logic             mem_op;
    logic             misaligned;
    logic             start;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_hit;
    logic [31:0]      fmt_data;

    assign size_in    = decode_size(mem_size);
    assign mem_op     = valid & (mem_read | mem_write);
    assign misaligned = ((size_in == HALF) && alu_data[0]) ||
                        ((size_in == WORD) && (alu_data[1:0] != 2'b00));
    // Gated by rst so stall stays low while reset is held.
    assign start       = rst && (state == IDLE) && mem_op && !misaligned;
    assign cnt_nxt     = cnt + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_nxt == TIMEOUT_CNT);

    load_formatter u_load_formatter (
        .drdata    (drdata),
        .addr      (lat_addr[1:0]),
        .size      (lat_size),
        .is_signed (lat_signed),
        .result    (fmt_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_rd     <= '0;
            lat_rw     <= 1'b0;
            lat_m2r    <= 1'b0;
            lat_addr   <= '0;
            lat_size   <= BYTE;
            lat_signed <= 1'b0;
            lat_read   <= 1'b0;
            err        <= 1'b0;
            ld_data    <= '0;
            bus_err    <= 1'b0;
            dreq       <= 1'b0;
            dwe        <= 1'b0;
            dbe        <= '0;
            daddr      <= '0;
            dwdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus_err <= 1'b0;
                    if (start) begin
                        lat_rd     <= rd;
                        lat_rw     <= reg_write;
                        lat_m2r    <= mem_2_reg;
                        lat_addr   <= alu_data;
                        lat_size   <= size_in;
                        lat_signed <= mem_signed;
                        lat_read   <= mem_read & ~mem_write;
                        cnt        <= '0;
                        err        <= 1'b0;
                        ld_data    <= '0;
                        dreq       <= 1'b1;
                        dwe        <= mem_write;
                        dbe        <= byte_mask(size_in, alu_data[1:0]);
                        daddr      <= {alu_data[31:2], 2'b00};
                        dwdata     <= store_lanes(size_in, store_data);
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (dack) begin
                        if (lat_read) ld_data <= fmt_data;
                        dreq  <= 1'b0;
                        dwe   <= 1'b0;
                        dbe   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt_nxt;
                        if (timeout_hit) begin
                            bus_err <= 1'b1;
                            err     <= 1'b1;
                            dreq    <= 1'b0;
                            dwe     <= 1'b0;
                            dbe     <= '0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus_err <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        reg_write_out = 1'b0;
        mem_2_reg_out = mem_2_reg;
        rd_out        = rd;
        alu_data_out  = alu_data;
        mem_data_out  = '0;
        stall         = 1'b0;
        addr_err      = 1'b0;
        case (state)
            IDLE: begin
                reg_write_out = valid & reg_write & ~mem_op;
                addr_err      = mem_op & misaligned;
                stall         = start;
            end
            BUS: begin
                stall         = 1'b1;
                mem_2_reg_out = 1'b0;
                rd_out        = '0;
                alu_data_out  = '0;
            end
            DONE: begin
                reg_write_out = lat_rw & ~err;
                mem_2_reg_out = lat_m2r;
                rd_out        = lat_rd;
                alu_data_out  = lat_addr;
                mem_data_out  = ld_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a queue of expected MEM/WB results.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mem_read, mem_write, mem_signed, reg_write, mem_2_reg;
    logic [1:0]  mem_size;
    logic [4:0]  rd;
    logic [31:0] alu_data, store_data;
    logic        reg_write_out, mem_2_reg_out;
    logic [4:0]  rd_out;
    logic [31:0] alu_data_out, mem_data_out;
    logic        stall, addr_err, bus_err, dreq, dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwdata;
    logic        dack;
    logic [31:0] drdata;

    int checks = 0;
    int errors = 0;
    int sc;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] md;
    } exp_t;

    exp_t sb[$];

    mem_access_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .mem_signed    (mem_signed),
        .reg_write     (reg_write),
        .mem_2_reg     (mem_2_reg),
        .rd            (rd),
        .alu_data      (alu_data),
        .store_data    (store_data),
        .reg_write_out (reg_write_out),
        .mem_2_reg_out (mem_2_reg_out),
        .rd_out        (rd_out),
        .alu_data_out  (alu_data_out),
        .mem_data_out  (mem_data_out),
        .stall         (stall),
        .addr_err      (addr_err),
        .bus_err       (bus_err),
        .dreq          (dreq),
        .dwe           (dwe),
        .dbe           (dbe),
        .daddr         (daddr),
        .dwdata        (dwdata),
        .dack          (dack),
        .drdata        (drdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [1:0] sz, input logic sgn,
                            input logic rw, input logic m2r, input logic [4:0] r,
                            input logic [31:0] a, input logic [31:0] sd);
        valid      = 1'b1;
        mem_read   = ld;
        mem_write  = st;
        mem_size   = sz;
        mem_signed = sgn;
        reg_write  = rw;
        mem_2_reg  = m2r;
        rd         = r;
        alu_data   = a;
        store_data = sd;
    endtask

    task automatic push_exp(input logic [4:0] r, input logic rw, input logic m2r,
                            input logic [31:0] a, input logic [31:0] md);
        exp_t e;
        e.rd  = r;
        e.rw  = rw;
        e.m2r = m2r;
        e.alu = a;
        e.md  = md;
        sb.push_back(e);
    endtask

    // Called right after a negedge with the op already driven; returns in the DONE cycle.
    task automatic run_op(input int ack_cycle, input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [4:0] exp_we_be, input logic [31:0] exp_wdata,
                          output int stall_cycles);
        int          bus_cycles = 0;
        logic [31:0] a0 = alu_data;
        logic [31:0] s0 = store_data;
        bit          done = 1'b0;
        stall_cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            dack   = 1'b0;
            drdata = 32'h5555_5555;
            #1;
            if (!stall) begin
                done = 1'b1;
            end else begin
                stall_cycles++;
                if (dreq) begin
                    bus_cycles++;
                    check("bus_daddr", daddr, exp_addr);
                    check("bus_dwe_dbe", 32'({dwe, dbe}), 32'(exp_we_be));
                    check("bus_dwdata", dwdata, exp_wdata);
                    // Upstream inputs change under the DUT; the bus side must not follow.
                    alu_data   = ~a0;
                    store_data = ~s0;
                    if (bus_cycles == ack_cycle) begin
                        dack   = 1'b1;
                        drdata = rdata;
                    end
                end
                @(negedge clk);
            end
        end
        check("op_completed", 32'(done), 32'd1);
    endtask

    task automatic check_done(input logic exp_bus_err);
        exp_t e;
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("done_reg_write", 32'(reg_write_out), 32'(e.rw));
            check("done_mem_2_reg", 32'(mem_2_reg_out), 32'(e.m2r));
            check("done_rd", 32'(rd_out), 32'(e.rd));
            check("done_alu_data", alu_data_out, e.alu);
            check("done_mem_data", mem_data_out, e.md);
        end
        check("done_dreq", 32'(dreq), 32'd0);
        check("done_bus_err", 32'(bus_err), 32'(exp_bus_err));
        valid     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_bus_err", 32'(bus_err), 32'd0);
        check("idle_dreq", 32'(dreq), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        valid = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_signed = 0;
        reg_write = 0; mem_2_reg = 0; rd = 0; alu_data = 0; store_data = 0;
        dack = 0; drdata = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_dreq", 32'(dreq), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_dbe", 32'(dbe), 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_dwdata", dwdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_mem_data", mem_data_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Non-memory op: zero-latency pass-through
        valid = 1; reg_write = 1; rd = 5'd5; alu_data = 32'h1234; mem_2_reg = 0;
        #1;
        check("pt_reg_write", 32'(reg_write_out), 32'd1);
        check("pt_rd", 32'(rd_out), 32'd5);
        check("pt_alu", alu_data_out, 32'h1234);
        check("pt_mem_data", mem_data_out, 32'd0);
        check("pt_stall", 32'(stall), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("pt_no_dreq", 32'(dreq), 32'd0);
        end
        valid = 0;
        #1;
        check("pt_invalid_reg_write", 32'(reg_write_out), 32'd0);
        @(negedge clk);

        // Signed byte load, dack on 3rd BUS cycle
        drive_op(1, 0, 2'd0, 1, 1, 1, 5'd7, 32'h1003, 32'h0);
        push_exp(5'd7, 1, 1, 32'h1003, 32'hFFFF_FF80);
        run_op(3, 32'h80FF_FF7F, 32'h1000, 5'b0_1000, 32'h0, sc);
        check("sbyte_stall_cycles", 32'(sc), 32'd4);
        check_done(0);

        // Half store, upper lanes
        drive_op(0, 1, 2'd1, 0, 0, 0, 5'd3, 32'h2002, 32'hAAAA_BEEF);
        push_exp(5'd3, 0, 0, 32'h2002, 32'h0);
        run_op(2, 32'h0, 32'h2000, 5'b1_1100, 32'hBEEF_BEEF, sc);
        check("hstore_stall_cycles", 32'(sc), 32'd3);
        check_done(0);

        // Unsigned half load, upper half
        drive_op(1, 0, 2'd1, 0, 1, 1, 5'd9, 32'h2002, 32'h0);
        push_exp(5'd9, 1, 1, 32'h2002, 32'h0000_8001);
        run_op(1, 32'h8001_1234, 32'h2000, 5'b0_1100, 32'h0, sc);
        check("uhalf_stall_cycles", 32'(sc), 32'd2);
        check_done(0);

        // Signed half load, lower half
        drive_op(1, 0, 2'd1, 1, 1, 1, 5'd10, 32'h6000, 32'h0);
        push_exp(5'd10, 1, 1, 32'h6000, 32'hFFFF_F00D);
        run_op(1, 32'h1234_F00D, 32'h6000, 5'b0_0011, 32'h0, sc);
        check_done(0);

        // Unsigned byte load, lane 1
        drive_op(1, 0, 2'd0, 0, 1, 1, 5'd11, 32'h7001, 32'h0);
        push_exp(5'd11, 1, 1, 32'h7001, 32'h0000_009A);
        run_op(1, 32'h0000_9A00, 32'h7000, 5'b0_0010, 32'h0, sc);
        check_done(0);

        // Byte store, lane 1
        drive_op(0, 1, 2'd0, 0, 0, 0, 5'd2, 32'h5001, 32'h1234_565A);
        push_exp(5'd2, 0, 0, 32'h5001, 32'h0);
        run_op(1, 32'h0, 32'h5000, 5'b1_0010, 32'h5A5A_5A5A, sc);
        check_done(0);

        // Word load with size encoding 3
        drive_op(1, 0, 2'd3, 1, 1, 1, 5'd13, 32'h4000, 32'h0);
        push_exp(5'd13, 1, 1, 32'h4000, 32'hDEAD_BEEF);
        run_op(1, 32'hDEAD_BEEF, 32'h4000, 5'b0_1111, 32'h0, sc);
        check("word_stall_cycles", 32'(sc), 32'd2);
        check_done(0);

        // Word store
        drive_op(0, 1, 2'd2, 0, 0, 0, 5'd14, 32'h8004, 32'hCAFE_F00D);
        push_exp(5'd14, 0, 0, 32'h8004, 32'h0);
        run_op(1, 32'h0, 32'h8004, 5'b1_1111, 32'hCAFE_F00D, sc);
        check_done(0);

        // Misaligned word load and half load
        drive_op(1, 0, 2'd2, 0, 1, 1, 5'd4, 32'h3001, 32'h0);
        #1;
        check("mis_addr_err", 32'(addr_err), 32'd1);
        check("mis_reg_write", 32'(reg_write_out), 32'd0);
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_dreq", 32'(dreq), 32'd0);
        @(negedge clk);
        #1;
        check("mis_no_bus", 32'(dreq), 32'd0);
        check("mis_still_idle", 32'(stall), 32'd0);
        mem_size = 2'd1;
        alu_data = 32'h3003;
        #1;
        check("mis_half_addr_err", 32'(addr_err), 32'd1);
        valid = 0;
        #1;
        check("mis_cleared", 32'(addr_err), 32'd0);
        @(negedge clk);

        // Timeout: no dack, TIMEOUT=4
        drive_op(1, 0, 2'd2, 0, 1, 1, 5'd12, 32'h9000, 32'h0);
        push_exp(5'd12, 0, 1, 32'h9000, 32'h0);
        run_op(0, 32'h0, 32'h9000, 5'b0_1111, 32'h0, sc);
        check("timeout_stall_cycles", 32'(sc), 32'd5);
        check_done(1);

        // Reset in the middle of a bus access
        drive_op(0, 1, 2'd2, 0, 0, 0, 5'd1, 32'hA000, 32'h1122_3344);
        @(negedge clk);
        #1;
        check("rstbus_dreq_before", 32'(dreq), 32'd1);
        rst = 1'b0;
        #1;
        check("rstbus_dreq", 32'(dreq), 32'd0);
        check("rstbus_stall", 32'(stall), 32'd0);
        check("rstbus_dbe", 32'(dbe), 32'd0);
        dack   = 1'b1;
        drdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        dack = 1'b0;
        valid = 0; mem_write = 0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_dreq", 32'(dreq), 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_mem_data", mem_data_out, 32'd0);
        @(negedge clk);

        drive_op(1, 0, 2'd2, 0, 1, 1, 5'd15, 32'hB000, 32'h0);
        push_exp(5'd15, 1, 1, 32'hB000, 32'h0BAD_F00D);
        run_op(1, 32'h0BAD_F00D, 32'hB000, 5'b0_1111, 32'h0, sc);
        check("post_rst_stall_cycles", 32'(sc), 32'd2);
        check_done(0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
